apb_cfg_regs: RTL and testbench

Parametrised APB configuration register file: NumRegs registers of RegDataWidth bits, mapped word-aligned from a runtime base address. Supports per-register read-only masking, hardware-side load ports, a configurable number of wait states and per-register write-strobe pulses. Sits behind an APB demux as the generic config/status block for peripheral IPs.

---
 rtl/apb_cfg_regs_pkg.sv | 26 ++
 rtl/apb_cfg_regs_intf.sv | 39 +++
 rtl/apb_cfg_regs.sv | 186 ++++++++++++++++++
 tb/tb_apb_cfg_regs.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_cfg_regs_pkg.sv
// Shared types and helpers for the APB configuration register file.
package apb_cfg_regs_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef logic [7:0] wait_cnt_t;

  // APB response encoding on pslverr
  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  // Byte-offset bits dropped from the address offset: registers sit on a
  // power-of-two stride at least as wide as the APB data bus.
  function automatic int stride_shift(input int data_w);
    return $clog2((data_w + 7) / 8);
  endfunction

  // Index width wide enough to also name the slot just past the last register.
  function automatic int idx_width(input int num_regs);
    return (num_regs < 1) ? 1 : $clog2(num_regs + 1);
  endfunction

endpackage

// File: rtl/apb_cfg_regs_intf.sv
// APB front end: turns the raw bus signals into an access strobe and a
// decoded register index relative to the runtime base address.
module apb_cfg_regs_intf
  import apb_cfg_regs_pkg::*;
#(
  parameter int NumRegs   = 16,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int IdxW      = 5
) (
  input  logic                 psel,
  input  logic                 penable,
  input  logic [AddrWidth-1:0] paddr,
  input  logic [AddrWidth-1:0] base_addr,
  output logic                 access,
  output logic                 reg_hit,
  output logic                 lock_hit,
  output logic [IdxW-1:0]      idx
);

  localparam int Shift = stride_shift(DataWidth);
  localparam logic [AddrWidth-1:0] NumRegsA = AddrWidth'(NumRegs);

  logic                 above_base;
  logic [AddrWidth-1:0] offset;
  logic [AddrWidth-1:0] word_idx;

  // Address decode; low offset bits inside a word are ignored
  always_comb begin
    access     = psel && penable;
    above_base = (paddr >= base_addr);
    offset     = paddr - base_addr;
    word_idx   = offset >> Shift;
    reg_hit    = above_base && (word_idx < NumRegsA);
    lock_hit   = above_base && (word_idx == NumRegsA);
    idx        = word_idx[IdxW-1:0];
  end

endmodule

// File: rtl/apb_cfg_regs.sv
// APB configuration register file with read-only masking, hardware load
// ports, programmable wait states and per-register write pulses.
// Optional: define APB_CFG_REGS_LOCK_EN for a sticky lock bit at index
// NumRegs that blocks all further APB writes until reset.
module apb_cfg_regs
  import apb_cfg_regs_pkg::*;
#(
  parameter int                 NumRegs      = 16,
  parameter int                 AddrWidth    = 32,
  parameter int                 DataWidth    = 32,
  parameter int                 RegDataWidth = 32,
  parameter int                 WaitCycles   = 0,
  parameter logic [NumRegs-1:0] ReadOnlyMask = '0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  psel_i,
  input  logic                                  penable_i,
  input  logic                                  pwrite_i,
  input  logic [AddrWidth-1:0]                  paddr_i,
  input  logic [DataWidth-1:0]                  pwdata_i,
  input  logic [(DataWidth+7)/8-1:0]            pstrb_i,
  output logic [DataWidth-1:0]                  prdata_o,
  output logic                                  pready_o,
  output logic                                  pslverr_o,
  input  logic [AddrWidth-1:0]                  base_addr_i,
  input  logic [NumRegs-1:0][RegDataWidth-1:0]  reg_init_i,
  input  logic [NumRegs-1:0]                    reg_load_i,
  input  logic [NumRegs-1:0][RegDataWidth-1:0]  reg_d_i,
  output logic [NumRegs-1:0][RegDataWidth-1:0]  reg_q_o,
  output logic [NumRegs-1:0]                    reg_wr_o
);

  localparam int StrbW = (DataWidth + 7) / 8;
  localparam int IdxW  = idx_width(NumRegs);

  logic                                 access;
  logic                                 reg_hit;
  logic                                 lock_hit;
  logic [IdxW-1:0]                      idx;
  state_e                               state_q, state_d;
  wait_cnt_t                            cnt_q, cnt_d, cur_cnt;
  logic                                 pready;
  logic                                 lock_q;
  logic                                 lock_hit_eff;
  logic                                 ro_hit;
  logic [RegDataWidth-1:0]              rd_val;
  logic [NumRegs-1:0]                   wr_sel;
  logic [NumRegs-1:0][RegDataWidth-1:0] reg_q;
  logic [NumRegs-1:0]                   reg_wr_q;
  logic                                 unused_inputs;

  // Upper data/strobe lanes are dropped when registers are narrower than the bus
  assign unused_inputs = ^{pwdata_i, pstrb_i};

  function automatic logic [RegDataWidth-1:0] merge_bytes(
    input logic [RegDataWidth-1:0] old_val,
    input logic [DataWidth-1:0]    wdata,
    input logic [StrbW-1:0]        strb
  );
    logic [RegDataWidth-1:0] res;
    res = old_val;
    for (int j = 0; j < RegDataWidth; j++) begin
      if (strb[j / 8]) res[j] = wdata[j];
    end
    return res;
  endfunction

  apb_cfg_regs_intf #(
    .NumRegs  (NumRegs),
    .AddrWidth(AddrWidth),
    .DataWidth(DataWidth),
    .IdxW     (IdxW)
  ) u_intf (
    .psel     (psel_i),
    .penable  (penable_i),
    .paddr    (paddr_i),
    .base_addr(base_addr_i),
    .access   (access),
    .reg_hit  (reg_hit),
    .lock_hit (lock_hit),
    .idx      (idx)
  );

  // FSM state and wait counter
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count access cycles; ready once WaitCycles of them have elapsed
  always_comb begin
    state_d = ST_IDLE;
    cnt_d   = '0;
    pready  = 1'b0;
    cur_cnt = (state_q == ST_ACCESS) ? cnt_q : '0;
    if (access && !rst_n) begin
      if (cur_cnt == wait_cnt_t'(WaitCycles)) begin
        pready = 1'b1;
      end else begin
        state_d = ST_ACCESS;
        cnt_d   = cur_cnt + 8'd1;
      end
    end
  end

`ifdef APB_CFG_REGS_LOCK_EN
  assign lock_hit_eff = lock_hit;

  // Sticky lock: set by an accepted write of 1 to bit 0, cleared only by reset
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      lock_q <= 1'b0;
    end else if (pready && pwrite_i && lock_hit && !lock_q && pstrb_i[0] && pwdata_i[0]) begin
      lock_q <= 1'b1;
    end
  end
`else
  logic unused_lock_hit;
  assign unused_lock_hit = lock_hit;
  assign lock_hit_eff    = 1'b0;
  assign lock_q          = 1'b0;
`endif

  // Select the addressed register and build the APB response
  always_comb begin
    rd_val    = '0;
    ro_hit    = 1'b0;
    wr_sel    = '0;
    prdata_o  = '0;
    pslverr_o = RESP_OKAY;
    for (int i = 0; i < NumRegs; i++) begin
      if (idx == IdxW'(i)) begin
        rd_val = reg_q[i];
        ro_hit = ReadOnlyMask[i];
        wr_sel[i] = pready && pwrite_i && reg_hit && !lock_q && !ReadOnlyMask[i];
      end
    end
    if (pready) begin
      if (!(reg_hit || lock_hit_eff)) begin
        pslverr_o = RESP_SLVERR;
      end else if (pwrite_i && (lock_q || (reg_hit && ro_hit))) begin
        pslverr_o = RESP_SLVERR;
      end
      if (!pwrite_i && reg_hit) begin
        prdata_o[RegDataWidth-1:0] = rd_val;
      end else if (!pwrite_i && lock_hit_eff) begin
        prdata_o[0] = lock_q;
      end
    end
  end

  // Register storage: hardware load takes priority over an APB commit
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      reg_q <= reg_init_i;
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        if (reg_load_i[i]) begin
          reg_q[i] <= reg_d_i[i];
        end else if (wr_sel[i]) begin
          reg_q[i] <= merge_bytes(reg_q[i], pwdata_i, pstrb_i);
        end
      end
    end
  end

  // One-cycle write pulse per register, raised even when a load overrides it
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      reg_wr_q <= '0;
    end else begin
      reg_wr_q <= wr_sel;
    end
  end

  assign pready_o = pready;
  assign reg_q_o  = reg_q;
  assign reg_wr_o = reg_wr_q;

endmodule

// File: tb/tb_apb_cfg_regs.sv
// Self-checking bench for apb_cfg_regs: directed cases plus randomized APB
// traffic and hardware loads, checked every cycle against a behavioural model.
module tb_apb_cfg_regs;

  localparam int NR  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int RDW = 16;
  localparam int WC  = 2;
  localparam logic [NR-1:0] RO = 4'b0100;
  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef APB_CFG_REGS_LOCK_EN
  localparam bit HAS_LOCK = 1'b1;
`else
  localparam bit HAS_LOCK = 1'b0;
`endif

  logic                     clk;
  logic                     rst_n;
  logic                     psel, penable, pwrite;
  logic [AW-1:0]            paddr;
  logic [DW-1:0]            pwdata;
  logic [DW/8-1:0]          pstrb;
  logic [DW-1:0]            prdata;
  logic                     pready, pslverr;
  logic [AW-1:0]            base_addr;
  logic [NR-1:0][RDW-1:0]   reg_init;
  logic [NR-1:0]            reg_load;
  logic [NR-1:0][RDW-1:0]   reg_d;
  logic [NR-1:0][RDW-1:0]   reg_q;
  logic [NR-1:0]            reg_wr;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  apb_cfg_regs #(
    .NumRegs(NR), .AddrWidth(AW), .DataWidth(DW), .RegDataWidth(RDW),
    .WaitCycles(WC), .ReadOnlyMask(RO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .base_addr_i(base_addr), .reg_init_i(reg_init),
    .reg_load_i(reg_load), .reg_d_i(reg_d),
    .reg_q_o(reg_q), .reg_wr_o(reg_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [RDW-1:0] m_q [NR];
  bit             m_lock;
  logic [NR-1:0]  m_wr;
  int             m_acc;   // access cycles already spent in the current transfer

  // -1 miss, 0..NR-1 register, NR lock bit
  function automatic int dec(input logic [31:0] a);
    logic [31:0] k;
    if (a < BASE) return -1;
    k = (a - BASE) / 4;
    if (k < NR) return int'(k);
    if (HAS_LOCK && k == NR) return NR;
    return -1;
  endfunction

  function automatic bit exp_ready();
    return !rst_n && psel && penable && (m_acc == WC);
  endfunction

  function automatic bit commit_to(input int i);
    return exp_ready() && pwrite && !m_lock && dec(paddr) == i && !RO[i];
  endfunction

  function automatic logic [RDW-1:0] next_q(input int i);
    logic [RDW-1:0] v;
    v = m_q[i];
    if (commit_to(i))
      for (int b = 0; b < RDW / 8; b++)
        if (pstrb[b]) v[8*b +: 8] = pwdata[8*b +: 8];
    if (reg_load[i]) v = reg_d[i];
    return v;
  endfunction

  function automatic bit exp_err();
    int d;
    d = dec(paddr);
    if (d < 0) return 1'b1;
    if (pwrite && m_lock) return 1'b1;
    if (pwrite && d < NR && RO[d]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_prdata();
    int d;
    d = dec(paddr);
    if (!exp_ready() || pwrite) return 32'h0;
    if (d >= 0 && d < NR) return {16'h0, m_q[d]};
    if (d == NR) return {31'h0, m_lock};
    return 32'h0;
  endfunction

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < NR; i++) m_q[i] <= reg_init[i];
      m_lock <= 1'b0;
      m_wr   <= '0;
      m_acc  <= 0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        m_q[i]  <= next_q(i);
        m_wr[i] <= commit_to(i);
      end
      if (exp_ready() && pwrite && !m_lock && dec(paddr) == NR && pstrb[0] && pwdata[0])
        m_lock <= 1'b1;
      if (exp_ready()) m_acc <= 0;
      else if (psel && penable) m_acc <= m_acc + 1;
      else m_acc <= 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("pready", {31'h0, pready}, {31'h0, exp_ready()});
      if (exp_ready()) check("pslverr", {31'h0, pslverr}, {31'h0, exp_err()});
      if (!exp_ready() || !pwrite) check("prdata", prdata, exp_prdata());
      for (int i = 0; i < NR; i++)
        check($sformatf("reg_q[%0d]", i), {16'h0, reg_q[i]}, {16'h0, m_q[i]});
      check("reg_wr", {28'h0, reg_wr}, {28'h0, m_wr});
    end
  end

  // ---------------- stimulus ----------------
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [NR-1:0] ld,
                      input logic [NR-1:0][RDW-1:0] ldd, input bit abort,
                      output logic [31:0] rd, output bit err, output int ncyc);
    bit done;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    reg_load = ld; reg_d = ldd;
    @(posedge clk); #1;
    penable = 1'b1;
    ncyc = 0; rd = '0; err = 1'b0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      ncyc++;
      if (pready) begin
        rd = prdata; err = pslverr; done = 1'b1;
      end else if (abort) begin
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL timeout: no pready after %0d access cycles, addr 0x%0h", ncyc, a);
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; reg_load = '0;
  endtask

  initial begin
    logic [31:0]            rd;
    bit                     err;
    int                     nc;
    logic [RDW-1:0]         keep;
    logic [NR-1:0][RDW-1:0] ldd;
    logic [NR-1:0]          ld;
    logic [31:0]            a;
    int                     r;

    rst_n = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    base_addr = BASE;
    reg_init = {16'h0123, 16'h7777, 16'hBEEF, 16'h00C3};
    reg_load = '0; reg_d = '0; ldd = '0;

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("rst_reg_q1", {16'h0, reg_q[1]}, 32'h0000_BEEF);
    check("rst_pready", {31'h0, pready}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;

    // Read with two wait states
    xfer(1'b0, 32'h1004, 32'h0, 4'h0, '0, ldd, 1'b0, rd, err, nc);
    check("t1_cycles", nc, 3);
    check("t1_prdata", rd, 32'h0000_BEEF);
    check("t1_err", {31'h0, err}, 32'h0);

    // Byte-strobed write
    xfer(1'b1, 32'h1000, 32'h1234_5678, 4'b0010, '0, ldd, 1'b0, rd, err, nc);
    check("t2_err", {31'h0, err}, 32'h0);
    check("t2_reg_q0", {16'h0, reg_q[0]}, 32'h0000_56C3);
    check("t2_wr_pulse", {28'h0, reg_wr}, 32'h1);
    @(posedge clk); #1;
    check("t2_wr_clear", {28'h0, reg_wr}, 32'h0);

    // Read-only register
    xfer(1'b1, 32'h1008, 32'hFFFF_FFFF, 4'hF, '0, ldd, 1'b0, rd, err, nc);
    check("t3_err", {31'h0, err}, 32'h1);
    check("t3_reg_q2", {16'h0, reg_q[2]}, 32'h0000_7777);
    check("t3_wr", {28'h0, reg_wr}, 32'h0);

    // Out-of-range addresses
    xfer(1'b0, 32'h0FFC, 32'h0, 4'h0, '0, ldd, 1'b0, rd, err, nc);
    check("t4_below_err", {31'h0, err}, 32'h1);
    check("t4_below_rd", rd, 32'h0);
`ifndef APB_CFG_REGS_LOCK_EN
    xfer(1'b0, 32'h1010, 32'h0, 4'h0, '0, ldd, 1'b0, rd, err, nc);
    check("t4_above_err", {31'h0, err}, 32'h1);
    check("t4_above_rd", rd, 32'h0);
`endif

    // Hardware load wins over a same-edge APB commit
    ldd = '0; ldd[1] = 16'hAAAA;
    xfer(1'b1, 32'h1004, 32'h0000_5555, 4'hF, 4'b0010, ldd, 1'b0, rd, err, nc);
    check("t5_err", {31'h0, err}, 32'h0);
    check("t5_reg_q1", {16'h0, reg_q[1]}, 32'h0000_AAAA);
    check("t5_wr_pulse", {28'h0, reg_wr}, 32'h2);

    // Dropped select mid-access must not commit
    xfer(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, '0, ldd, 1'b1, rd, err, nc);
    repeat (2) @(posedge clk); #1;
    check("abort_reg_q0", {16'h0, reg_q[0]}, 32'h0000_56C3);

`ifdef APB_CFG_REGS_LOCK_EN
    xfer(1'b1, 32'h1010, 32'h0000_0001, 4'h1, '0, ldd, 1'b0, rd, err, nc);
    check("t6_lock_err", {31'h0, err}, 32'h0);
    xfer(1'b0, 32'h1010, 32'h0, 4'h0, '0, ldd, 1'b0, rd, err, nc);
    check("t6_lock_rd", rd, 32'h1);
    keep = reg_q[0];
    xfer(1'b1, 32'h1000, 32'hCAFE_CAFE, 4'hF, '0, ldd, 1'b0, rd, err, nc);
    check("t6_locked_err", {31'h0, err}, 32'h1);
    check("t6_locked_q0", {16'h0, reg_q[0]}, {16'h0, keep});
`endif

    // Reset in the middle of an access
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1000;
    pwdata = 32'h0000_9999; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_rst_pready", {31'h0, pready}, 32'h0);
    check("t6_rst_q0", {16'h0, reg_q[0]}, 32'h0000_00C3);
    check("t6_rst_q1", {16'h0, reg_q[1]}, 32'h0000_BEEF);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    xfer(1'b1, 32'h1000, 32'h0000_4321, 4'hF, '0, ldd, 1'b0, rd, err, nc);
    check("t6_unlocked_err", {31'h0, err}, 32'h0);
    check("t6_unlocked_q0", {16'h0, reg_q[0]}, 32'h0000_4321);

    // Randomized traffic with sparse hardware loads and occasional aborts
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 7);
      if (r == 0) a = BASE - 32'h4;
      else if (r == 7) a = BASE + 32'h100 + $urandom_range(0, 255);
      else a = BASE + 32'(4 * (r - 1)) + $urandom_range(0, 3);
      for (int i = 0; i < NR; i++) ldd[i] = RDW'($urandom);
      ld = ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0;
      xfer(1'($urandom), a, $urandom, 4'($urandom), ld, ldd,
           ($urandom_range(0, 9) == 0), rd, err, nc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
